// File: rtl/fifo_packetizer.sv
// fifo_packetizer: sole reader of the fifo read port. It frames fifo words
// into packets on a valid/ready stream: a header word carrying the sync
// pattern, the sequence number and the payload length, followed by up to
// PKT_LEN payload words. A partial fill that sits idle for TIMEOUT cycles is
// flushed as a short packet. Payload words pass through a 2-entry skid buffer,
// which absorbs the one-cycle fifo read latency without losing throughput.
module fifo_packetizer #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_BITS  = 10,
    parameter int          PKT_LEN    = 16,
    parameter int          TIMEOUT    = 64,
    parameter logic [15:0] SYNC_WORD  = 16'hA5A5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_BITS-1:0]  fifo_usedw,
    output logic                  fifo_rd_req,
    output logic [DATA_WIDTH-1:0] pkt_data,
    output logic                  pkt_valid,
    output logic                  pkt_sop,
    output logic                  pkt_eop,
    input  logic                  pkt_ready,
    output logic [7:0]            seq,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    // Counter wide enough to hold TIMEOUT; a 1-bit stub when the flush is disabled.
    localparam int                   TMO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [ADDR_BITS-1:0] PKT_LEN_U = ADDR_BITS'(PKT_LEN);
    localparam logic [7:0]           PKT_LEN_B = 8'(PKT_LEN);
    localparam bit                   TMO_EN    = (TIMEOUT > 0);

    state_t                  state_r;
    state_t                  state_s;
    logic [7:0]              len_r;
    logic [7:0]              len_s;
    logic [7:0]              seq_r;
    logic [7:0]              seq_s;
    logic [TMO_W-1:0]        tmo_cnt_r;
    logic [TMO_W-1:0]        tmo_cnt_s;

    logic [7:0]              reads_issued_r;
    logic [7:0]              words_sent_r;
    logic                    inflight_r;

    logic [DATA_WIDTH-1:0]   buf0_r;
    logic [DATA_WIDTH-1:0]   buf1_r;
    logic [1:0]              buf_count_r;

    logic                    head_valid_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    eop_s;
    logic                    rd_req_s;
    logic [2:0]              occ_s;
    logic [DATA_WIDTH-1:0]   hdr_word_s;

    assign head_valid_s = (buf_count_r != 2'd0);
    assign pop_s        = (state_r == ST_PAYLOAD) && head_valid_s && pkt_ready;
    assign push_s       = inflight_r;
    assign eop_s        = (state_r == ST_PAYLOAD) && head_valid_s &&
                          (words_sent_r == (len_r - 8'd1));

    // Words held or arriving after this cycle's pop; reads stop once two are committed.
    assign occ_s    = {1'b0, buf_count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign rd_req_s = (state_r == ST_PAYLOAD) && (reads_issued_r < len_r) &&
                      !fifo_empty && (occ_s < 3'd2);

    assign hdr_word_s  = DATA_WIDTH'({SYNC_WORD, seq_r, len_r});
    assign fifo_rd_req = rd_req_s;
    assign seq         = seq_r;
    assign busy        = (state_r != ST_IDLE);

    // Control state: FSM state, latched packet length, sequence number, idle timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            len_r     <= 8'd0;
            seq_r     <= 8'd0;
            tmo_cnt_r <= '0;
        end else begin
            state_r   <= state_s;
            len_r     <= len_s;
            seq_r     <= seq_s;
            tmo_cnt_r <= tmo_cnt_s;
        end
    end

    // Next-state logic: packet start decisions in IDLE, header handshake, payload end.
    always_comb begin
        state_s   = state_r;
        len_s     = len_r;
        seq_s     = seq_r;
        tmo_cnt_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (en && (fifo_usedw >= PKT_LEN_U)) begin
                    // A full packet is available: takes priority over the flush timer.
                    len_s   = PKT_LEN_B;
                    state_s = ST_HDR;
                end else if (TMO_EN && en && (fifo_usedw != '0)) begin
                    // Partial fill: flush once it has been idle for TIMEOUT cycles.
                    if (tmo_cnt_r >= TMO_LAST) begin
                        len_s   = 8'(fifo_usedw);
                        state_s = ST_HDR;
                    end else begin
                        tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                    end
                end else begin
                    tmo_cnt_s = '0;
                end
            end
            ST_HDR: begin
                if (pkt_ready) begin
                    state_s = ST_PAYLOAD;
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                if (pop_s && eop_s) begin
                    state_s = ST_IDLE;
                    seq_s   = seq_r + 8'd1;
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Payload bookkeeping: reads issued, words delivered, read-in-flight flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reads_issued_r <= 8'd0;
            words_sent_r   <= 8'd0;
            inflight_r     <= 1'b0;
        end else begin
            inflight_r <= rd_req_s;
            if ((state_r == ST_PAYLOAD) && !(pop_s && eop_s)) begin
                if (rd_req_s) begin
                    reads_issued_r <= reads_issued_r + 8'd1;
                end
                if (pop_s) begin
                    words_sent_r <= words_sent_r + 8'd1;
                end
            end else begin
                reads_issued_r <= 8'd0;
                words_sent_r   <= 8'd0;
            end
        end
    end

    // Skid buffer: buf0 is the head presented downstream, buf1 the overflow slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0_r      <= '0;
            buf1_r      <= '0;
            buf_count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (buf_count_r == 2'd0) begin
                        buf0_r <= fifo_data;
                    end else begin
                        buf1_r <= fifo_data;
                    end
                    buf_count_r <= buf_count_r + 2'd1;
                end
                2'b01: begin
                    buf0_r      <= buf1_r;
                    buf_count_r <= buf_count_r - 2'd1;
                end
                2'b11: begin
                    if (buf_count_r == 2'd1) begin
                        buf0_r <= fifo_data;
                    end else begin
                        buf0_r <= buf1_r;
                        buf1_r <= fifo_data;
                    end
                end
                default: begin
                    buf_count_r <= buf_count_r;
                end
            endcase
        end
    end

    // Stream outputs: header word in HDR, buffer head in PAYLOAD, idle otherwise.
    always_comb begin
        pkt_data  = '0;
        pkt_valid = 1'b0;
        pkt_sop   = 1'b0;
        pkt_eop   = 1'b0;
        case (state_r)
            ST_HDR: begin
                pkt_data  = hdr_word_s;
                pkt_valid = 1'b1;
                pkt_sop   = 1'b1;
            end
            ST_PAYLOAD: begin
                if (head_valid_s) begin
                    pkt_data  = buf0_r;
                    pkt_valid = 1'b1;
                    pkt_eop   = eop_s;
                end else begin
                    pkt_data  = '0;
                    pkt_valid = 1'b0;
                    pkt_eop   = 1'b0;
                end
            end
            default: begin
                pkt_data  = '0;
                pkt_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_packetizer.sv
// Bench for fifo_packetizer: a queue-based fifo with one-cycle read latency
// feeds the DUT; a scoreboard predicts every handshaken word from the words
// written and the packet lengths each scenario expects.
module tb_fifo_packetizer;

    localparam int DW  = 32;
    localparam int AB  = 10;
    localparam int PL  = 16;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic [AB-1:0] fifo_usedw = '0;
    logic          fifo_rd_req;
    logic [DW-1:0] pkt_data;
    logic          pkt_valid;
    logic          pkt_sop;
    logic          pkt_eop;
    logic          pkt_ready = 1'b0;
    logic [7:0]    seq;
    logic          busy;

    fifo_packetizer #(
        .DATA_WIDTH(DW), .ADDR_BITS(AB), .PKT_LEN(PL), .TIMEOUT(TMO), .SYNC_WORD(16'hA5A5)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw),
        .fifo_rd_req(fifo_rd_req),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
        .pkt_ready(pkt_ready), .seq(seq), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] fq[$];
    logic [31:0] src[$];
    int          exp_len[$];
    int          remaining = 0;
    int          cur_len = 0;
    logic [7:0]  seq_m = 8'd0;
    int          rd_total = 0;
    int          pay_total = 0;
    bit          rd_seen = 1'b0;
    int          cyc = 0;
    int          feed_left = 0;
    int          ready_mode = 0;
    int          pat_idx = 0;
    bit          en_cfg = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    bit          prev_sop = 1'b0;
    bit          prev_eop = 1'b0;
    logic [31:0] prev_data = '0;
    int          last_eop_cyc = 0;
    int          first_pay_cyc = 0;
    int          gap_last = 0;
    logic [31:0] last_hdr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Sample DUT outputs at the falling edge and run the scoreboard.
    task automatic observe();
        logic [31:0] e;
        if (fifo_rd_req) begin
            check("rd_while_empty", 64'(fifo_empty), 64'(0));
            rd_total++;
        end
        rd_seen = fifo_rd_req;
        if (prev_valid && !prev_ready)
            check("stall_hold", 64'({pkt_valid, pkt_sop, pkt_eop, pkt_data}),
                  64'({1'b1, prev_sop, prev_eop, prev_data}));
        if (pkt_sop || pkt_eop)
            check("sop_eop_exclusive", 64'(pkt_sop && pkt_eop), 64'(0));
        if (pkt_valid && pkt_sop && !(prev_valid && prev_sop))
            gap_last = cyc - last_eop_cyc - 1;
        if (pkt_valid && pkt_ready && pkt_sop) begin
            check("hdr_not_mid_packet", 64'(remaining), 64'(0));
            check("hdr_expected", 64'(exp_len.size() != 0), 64'(1));
            cur_len = (exp_len.size() != 0) ? exp_len.pop_front() : 1;
            last_hdr = pkt_data;
            check("header", 64'(pkt_data), 64'({16'hA5A5, seq_m, 8'(cur_len)}));
            remaining = cur_len;
        end else if (pkt_valid && pkt_ready) begin
            pay_total++;
            check("payload_in_packet", 64'(remaining != 0), 64'(1));
            if (remaining == cur_len) first_pay_cyc = cyc;
            e = 32'hDEAD_BEEF;
            if (src.size() != 0) e = src.pop_front();
            check("payload_data", 64'(pkt_data), 64'(e));
            check("eop_flag", 64'(pkt_eop), 64'(remaining == 1));
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    last_eop_cyc = cyc;
                    seq_m = seq_m + 8'd1;
                end
            end
        end
        if (fifo_rd_req)
            check("outstanding_le2", 64'((rd_total - pay_total) <= 2), 64'(1));
        prev_valid = pkt_valid;
        prev_ready = pkt_ready;
        prev_sop   = pkt_sop;
        prev_eop   = pkt_eop;
        prev_data  = pkt_data;
    endtask

    // One clock: fifo model and inputs update after the rising edge, check at the falling edge.
    task automatic cycle();
        logic [31:0] w;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_seen && fq.size() > 0) fifo_data = fq.pop_front();
        if (feed_left > 0 && fq.size() < 40) begin
            w = $urandom;
            fq.push_back(w);
            src.push_back(w);
            feed_left--;
        end
        fifo_empty = (fq.size() == 0);
        fifo_usedw = AB'(fq.size());
        en = en_cfg;
        case (ready_mode)
            0: pkt_ready = 1'b1;
            1: begin
                pkt_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
                pat_idx++;
            end
            2: pkt_ready = ($urandom_range(0, 1) != 0);
            default: pkt_ready = 1'b0;
        endcase
        @(negedge clk);
        observe();
    endtask

    task automatic fill(input int n, input logic [31:0] base, input bit rnd);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? $urandom : (base + 32'(i));
            fq.push_back(w);
            src.push_back(w);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while ((exp_len.size() != 0 || remaining != 0) && k < budget) begin
            cycle();
            k++;
        end
        check(tag, 64'(k < budget), 64'(1));
        repeat (2) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(pkt_valid), 64'(0));
        check({tag, "_sop_eop"}, 64'({pkt_sop, pkt_eop}), 64'(0));
        check({tag, "_data"}, 64'(pkt_data), 64'(0));
        check({tag, "_rd_req"}, 64'(fifo_rd_req), 64'(0));
        check({tag, "_seq"}, 64'(seq), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    // Asynchronous reset pulse placed between clock edges; the fifo is flushed with it.
    task automatic reset_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        fq.delete();
        src.delete();
        exp_len.delete();
        remaining = 0;
        seq_m = 8'd0;
        rd_total = 0;
        pay_total = 0;
        rd_seen = 1'b0;
        prev_valid = 1'b0;
        feed_left = 0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int q;
        int r0;
        #1 rst = 1'b1;
        #2;
        check_reset_outputs("init");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cycle();

        // Full packet, incrementing data, ready held high.
        ready_mode = 0;
        en_cfg = 1'b1;
        r0 = rd_total;
        fill(16, 32'h100, 1'b0);
        exp_len.push_back(16);
        wait_done(200, "t1_done");
        check("t1_rd_pulses", 64'(rd_total - r0), 64'(16));
        check("t1_back_to_back", 64'(last_eop_cyc - first_pay_cyc), 64'(PL - 1));
        check("t1_seq", 64'(seq), 64'(1));
        check("t1_idle", 64'(busy), 64'(0));

        // Short packet flushed by the idle timeout.
        fill(3, 32'h200, 1'b0);
        exp_len.push_back(3);
        r0 = rd_total;
        q = 0;
        while (!pkt_valid && q < 300) begin
            cycle();
            if (!pkt_valid) q++;
        end
        check("t2_quiet_cycles", 64'(q >= TMO && q <= TMO + 1), 64'(1));
        check("t2_no_early_reads", 64'(rd_total - r0), 64'(0));
        wait_done(100, "t2_done");

        // Backpressure with a 1,0,0,1 ready pattern, then random ready over three packets.
        ready_mode = 1;
        pat_idx = 0;
        fill(16, 32'h0, 1'b1);
        exp_len.push_back(16);
        wait_done(300, "t3_done");
        ready_mode = 2;
        fill(48, 32'h0, 1'b1);
        repeat (3) exp_len.push_back(16);
        wait_done(800, "t3r_done");
        check("t3_seq", 64'(seq), 64'(seq_m));

        // Reset in the middle of the payload, then a clean packet at seq 0.
        ready_mode = 0;
        fill(16, 32'h0, 1'b1);
        exp_len.push_back(16);
        q = 0;
        while (!(remaining > 0 && (cur_len - remaining) == 5) && q < 100) begin
            cycle();
            q++;
        end
        check("t5_reached_word5", 64'(q < 100), 64'(1));
        reset_pulse("t5_rst");
        fill(16, 32'h0, 1'b1);
        exp_len.push_back(16);
        wait_done(200, "t5_done");
        check("t5_hdr_after_reset", 64'(last_hdr), 64'(32'hA5A50010));

        // en low blocks new starts; on enable one full packet, then a timed-out short one.
        en_cfg = 1'b0;
        fill(20, 32'h0, 1'b1);
        q = 0;
        repeat (100) begin
            cycle();
            if (fifo_rd_req || pkt_valid) q++;
        end
        check("t6_quiet_while_disabled", 64'(q), 64'(0));
        r0 = rd_total;
        en_cfg = 1'b1;
        exp_len.push_back(16);
        exp_len.push_back(4);
        wait_done(400, "t6_done");
        check("t6_rd_total", 64'(rd_total - r0), 64'(20));
        check("t6_flush_gap", 64'(gap_last >= TMO && gap_last <= TMO + 1), 64'(1));

        // 257 consecutive full packets from seq 0: sequence wraps through 255 to 0.
        reset_pulse("t7_rst");
        fill(40, 32'h0, 1'b1);
        feed_left = 257 * PL - 40;
        repeat (257) exp_len.push_back(16);
        wait_done(257 * 25, "t7_done");
        check("t7_last_hdr", 64'(last_hdr), 64'(32'hA5A50010));
        check("t7_seq", 64'(seq), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_packetizer.md
Name: fifo_packetizer

Overview:
- Drains the read side of the fifo block and frames its contents into packets on a valid/ready stream: one header word, then a payload of up to PKT_LEN words.
- Runs on the fifo read clock and is the fifo's only reader.
- Flushes short packets after a configurable idle timeout, so low-rate data is not stranded in the fifo.

Parameters:
- DATA_WIDTH, 32, width of fifo words and packet words (min 32).
- ADDR_BITS, 10, width of the fifo usedw count.
- PKT_LEN, 16, full payload length in words (1..255).
- TIMEOUT, 64, idle cycles with a partial fill before a short packet is flushed (0 disables flush).
- SYNC_WORD, 16'hA5A5, header sync pattern.

Ports:
- clk  in  1  fifo read clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  permits starting new packets.
- fifo_data  in  DATA_WIDTH  fifo data_out.
- fifo_empty  in  1  fifo empty flag.
- fifo_usedw  in  ADDR_BITS  fifo fill count.
- fifo_rd_req  out  1  fifo read request.
- pkt_data  out  DATA_WIDTH  packet word.
- pkt_valid  out  1  pkt_data valid.
- pkt_sop  out  1  header word marker.
- pkt_eop  out  1  last payload word marker.
- pkt_ready  in  1  downstream accepts the word when valid and ready are both high.
- seq  out  8  sequence number of the next/current packet.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, seq=0, timeout counter 0, skid buffer empty, in-flight read cleared. A reset mid-packet truncates the packet; no eop is emitted.
- Fifo read latency: fifo_data is valid exactly 1 cycle after fifo_rd_req=1 is sampled. fifo_rd_req is never asserted while fifo_empty=1.
- States: IDLE, HDR, PAYLOAD.
- IDLE, full packet: if en=1 and fifo_usedw>=PKT_LEN, latch len=PKT_LEN and go to HDR.
- IDLE, partial fill: if en=1, TIMEOUT!=0 and 0<fifo_usedw<PKT_LEN, increment the timeout counter. When the counter reaches TIMEOUT, latch len=fifo_usedw[7:0] and go to HDR.
- IDLE, timeout counter clear: the counter clears whenever fifo_usedw==0, fifo_usedw>=PKT_LEN, en=0, or on leaving IDLE.
- IDLE, priority: the full-packet check wins over timeout in the same cycle.
- HDR: drive pkt_data = {zero-extend, SYNC_WORD, seq, len}, with len in bits [7:0], seq in [15:8] and SYNC_WORD in [31:16]. Assert pkt_valid=1 and pkt_sop=1. Hold until pkt_ready, then go to PAYLOAD.
- PAYLOAD, skid buffer: a 2-entry internal buffer fed from fifo_data. pkt_data/pkt_valid come from the buffer head.
- PAYLOAD, read issue: assert fifo_rd_req when reads_issued<len, fifo_empty=0, and (buf_count + inflight − pop_this_cycle) < 2. This sustains 1 word/cycle with pkt_ready held high.
- PAYLOAD, eop: pkt_eop=1 on the word with words_sent==len−1.
- PAYLOAD, exit: after the eop handshake, seq increments (255 wraps to 0) and the state returns to IDLE. A new packet may start no earlier than the next cycle.
- Backpressure (pkt_ready=0): pkt_data, pkt_valid, pkt_sop and pkt_eop hold stable. At most 2 words are buffered and reads stall.
- en=0 mid-packet: the current packet completes normally; only new starts are blocked.
- pkt_sop and pkt_eop are never high in the same cycle. A packet always carries at least 1 payload word.

Test Plan:
- Fill 16 words 0x100..0x10F, en=1, pkt_ready=1 -> fifo_rd_req pulses 16 times. Stream is header 0xA5A50010 (sop), then 0x100..0x10F back-to-back, eop on 0x10F. seq becomes 1.
- Fill 3 words, TIMEOUT=64 -> no activity for 64 cycles. Then header 0xA5A50003 plus 3 payload words, eop on the 3rd.
- Full packet with pkt_ready toggled 1,0,0,1 repeatedly -> no word is lost or duplicated, outputs stay stable while stalled, and at most 2 reads are ever outstanding beyond consumption.
- 257 consecutive full packets -> seq field counts 0..255, then 0. Packet 257's header is 0xA5A50010.
- rst pulsed during PAYLOAD after 5 words -> all outputs 0 immediately (async), seq=0, state IDLE. The next packet starts cleanly with a header at seq 0.
- en=0 with 20 words in the fifo -> no reads and no pkt_valid. When en rises, one full packet is sent and 4 words remain, flushed after TIMEOUT.
